// File: rtl/noc_packet_tx_pkg.sv
// noc_packet_tx_pkg: shared types and widths for the NoC packet injector and its output register.
package noc_packet_tx_pkg;
  localparam int NOC_DATA_WIDTH = 32;
  localparam int SEQ_W = 8;
  typedef enum logic [1:0] {IDLE, WAIT_VC, BODY} tx_state_t;
endpackage

// File: rtl/noc_tx_flit_reg.sv
// noc_tx_flit_reg: one-entry output register for {flit, is_header, is_tail} with valid/ready hold.
module noc_tx_flit_reg
  import noc_packet_tx_pkg::*;
#(
  parameter int FLIT_W = NOC_DATA_WIDTH
) (
  input  logic              noc_clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [FLIT_W-1:0] d_flit,
  input  logic              d_header,
  input  logic              d_tail,
  input  logic              ready,
  output logic              valid,
  output logic [FLIT_W-1:0] flit,
  output logic              is_header,
  output logic              is_tail,
  output logic              can_load
);
  assign can_load = !valid || ready;
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      valid     <= 1'b0;
      flit      <= '0;
      is_header <= 1'b0;
      is_tail   <= 1'b0;
    end else if (load) begin
      valid     <= 1'b1;
      flit      <= d_flit;
      is_header <= d_header;
      is_tail   <= d_tail;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/noc_packet_tx.sv
// noc_packet_tx: local-side packet injector emitting header/body/tail flits toward the NoC.
// Optional NOC_TX_SEQNUM_EN: stamps an 8-bit packet sequence number into header bits [7:0].
module noc_packet_tx
  import noc_packet_tx_pkg::*;
#(
  parameter int                   FLIT_W  = NOC_DATA_WIDTH,
  parameter int                   COORD_W = 4,
  parameter int                   LEN_W   = 8,
  parameter logic [COORD_W-1:0]   MY_X    = '0,
  parameter logic [COORD_W-1:0]   MY_Y    = '0
) (
  input  logic               noc_clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [COORD_W-1:0] req_dst_x,
  input  logic [COORD_W-1:0] req_dst_y,
  input  logic [LEN_W-1:0]   req_len,
  input  logic               pl_valid,
  output logic               pl_ready,
  input  logic [FLIT_W-1:0]  pl_data,
  output logic               Noc_sender_valid,
  input  logic               Noc_sender_ready,
  output logic [FLIT_W-1:0]  Noc_sender_flit,
  input  logic               Noc_sender_VCready,
  output logic               Noc_sender_is_header,
  output logic               Noc_sender_is_tail,
  output logic               busy
);
  localparam int HDR_DX_LSB  = FLIT_W - COORD_W;
  localparam int HDR_DY_LSB  = HDR_DX_LSB - COORD_W;
  localparam int HDR_SX_LSB  = HDR_DY_LSB - COORD_W;
  localparam int HDR_SY_LSB  = HDR_SX_LSB - COORD_W;
  localparam int HDR_LEN_LSB = HDR_SY_LSB - LEN_W;
  tx_state_t          state, next;
  logic [COORD_W-1:0] dst_x, dst_y;
  logic [LEN_W-1:0]   len_q, remaining;
  logic [FLIT_W-1:0]  hdr, d_flit;
  logic [SEQ_W-1:0]   seq_hdr;
  logic               load, d_header, d_tail, can_load;
`ifdef NOC_TX_SEQNUM_EN
  logic [SEQ_W-1:0] seq;
  logic             tail_fire;
  assign tail_fire = Noc_sender_valid && Noc_sender_ready && Noc_sender_is_tail;
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) seq <= '0;
    else if (tail_fire) seq <= seq + 1'b1;
  end
  // a tail leaving on the same edge the next header loads must already count
  assign seq_hdr = seq + SEQ_W'(tail_fire);
`else
  assign seq_hdr = '0;
`endif
  always_comb begin
    hdr = '0;
    hdr[HDR_DX_LSB +: COORD_W]  = dst_x;
    hdr[HDR_DY_LSB +: COORD_W]  = dst_y;
    hdr[HDR_SX_LSB +: COORD_W]  = MY_X;
    hdr[HDR_SY_LSB +: COORD_W]  = MY_Y;
    hdr[HDR_LEN_LSB +: LEN_W]   = len_q;
    hdr[SEQ_W-1:0]              = seq_hdr;
  end
  always_comb begin
    next     = state;
    load     = 1'b0;
    d_flit   = hdr;
    d_header = 1'b0;
    d_tail   = 1'b0;
    pl_ready = 1'b0;
    case (state)
      IDLE: next = (req_valid && req_ready) ? WAIT_VC : IDLE;
      WAIT_VC: if (Noc_sender_VCready && can_load) begin
        load     = 1'b1;
        d_header = 1'b1;
        d_tail   = len_q == '0;
        next     = len_q == '0 ? IDLE : BODY;
      end
      BODY: begin
        pl_ready = can_load;
        if (pl_valid && can_load) begin
          load   = 1'b1;
          d_flit = pl_data;
          d_tail = remaining == LEN_W'(1);
          next   = remaining == LEN_W'(1) ? IDLE : BODY;
        end
      end
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge noc_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      dst_x     <= '0;
      dst_y     <= '0;
      len_q     <= '0;
      remaining <= '0;
    end else begin
      state     <= next;
      req_ready <= next == IDLE;
      if (state == IDLE && req_valid && req_ready) begin
        dst_x <= req_dst_x;
        dst_y <= req_dst_y;
        len_q <= req_len;
      end
      if (state == WAIT_VC && load) remaining <= len_q;
      if (state == BODY && load) remaining <= remaining - 1'b1;
    end
  end
  noc_tx_flit_reg #(.FLIT_W(FLIT_W)) u_flit_reg (
    .noc_clk   (noc_clk),
    .rst_n     (rst_n),
    .load      (load),
    .d_flit    (d_flit),
    .d_header  (d_header),
    .d_tail    (d_tail),
    .ready     (Noc_sender_ready),
    .valid     (Noc_sender_valid),
    .flit      (Noc_sender_flit),
    .is_header (Noc_sender_is_header),
    .is_tail   (Noc_sender_is_tail),
    .can_load  (can_load)
  );
  assign busy = state != IDLE || Noc_sender_valid;
endmodule

// File: tb/tb_noc_packet_tx.sv
// tb_noc_packet_tx: scoreboard bench for noc_packet_tx (flits checked in order as they are accepted).
module tb_noc_packet_tx;
  logic        noc_clk = 0, rst_n = 0, req_valid = 0, pl_valid = 0;
  logic [3:0]  req_dst_x = 0, req_dst_y = 0;
  logic [7:0]  req_len = 0;
  logic [31:0] pl_data = 0;
  logic        snd_ready = 1, vc_ready = 1;
  logic        req_ready, pl_ready, snd_valid, is_header, is_tail, busy;
  logic [31:0] flit;
  logic [33:0] cur, prev;
  logic [33:0] sb[$];
  int          total = 0, bad = 0, pkt_cnt = 0;
  bit          rnd_ready = 0, stall = 0;

  always #5 noc_clk = ~noc_clk;

  noc_packet_tx dut (
    .noc_clk(noc_clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dst_x(req_dst_x), .req_dst_y(req_dst_y), .req_len(req_len),
    .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
    .Noc_sender_valid(snd_valid), .Noc_sender_ready(snd_ready),
    .Noc_sender_flit(flit), .Noc_sender_VCready(vc_ready),
    .Noc_sender_is_header(is_header), .Noc_sender_is_tail(is_tail),
    .busy(busy)
  );

  assign cur = {flit, is_header, is_tail};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mk_hdr(input logic [3:0] x, input logic [3:0] y, input logic [7:0] len);
    logic [7:0] s;
    s = '0;
`ifdef NOC_TX_SEQNUM_EN
    s = pkt_cnt[7:0];
`endif
    return {x, y, 4'd0, 4'd0, len, s};
  endfunction

  initial forever begin
    @(posedge noc_clk);
    #1;
    snd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // transfers happen at the next posedge; inputs and outputs are settled at the negedge
  always @(negedge noc_clk) begin
    if (stall && rst_n) chk("hold", 64'(cur), 64'(prev));
    if (rst_n && snd_valid && snd_ready) begin
      if (sb.size() == 0) chk("extra", 64'(cur), 64'd0);
      else chk("flit", 64'(cur), 64'(sb.pop_front()));
    end
    stall = rst_n && snd_valid && !snd_ready;
    prev  = cur;
  end

  task automatic do_req(input logic [3:0] x, input logic [3:0] y, input logic [7:0] len, input logic [31:0] hv);
    int n = 0;
    bit hs = 0;
    req_valid = 1; req_dst_x = x; req_dst_y = y; req_len = len;
    sb.push_back({hv, 1'b1, len == 8'd0});
    do begin
      @(negedge noc_clk); hs = req_ready;
      @(posedge noc_clk); #1; n++;
    end while (!hs && n < 200);
    if (!hs) chk("req_timeout", 0, 1);
    req_valid = 0;
    pkt_cnt++;
  endtask

  task automatic do_body(input logic [31:0] d, input bit last);
    int n = 0;
    bit hs = 0;
    sb.push_back({d, 1'b0, last});
    pl_valid = 1; pl_data = d;
    do begin
      @(negedge noc_clk); hs = pl_ready;
      @(posedge noc_clk); #1; n++;
    end while (!hs && n < 200);
    if (!hs) chk("pl_timeout", 0, 1);
    pl_valid = 0;
  endtask

  task automatic send_pkt(input logic [3:0] x, input logic [3:0] y, input logic [7:0] len);
    do_req(x, y, len, mk_hdr(x, y, len));
    for (int i = 0; i < int'(len); i++) do_body($urandom, i == int'(len) - 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || snd_valid) && n < 2000) begin
      @(posedge noc_clk); #1; n++;
    end
    chk("drain", 64'(sb.size()), 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge noc_clk);
    #1;
    chk("rst_valid", snd_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pl_ready", pl_ready, 0);
    chk("rst_flit", 64'(cur), 0);
    rst_n = 1;
    @(posedge noc_clk); #1;
    chk("idle_req_ready", req_ready, 1);
    // basic packet with the documented header value
    do_req(4'd2, 4'd3, 8'd3, 32'h2300_0300);
    do_body(32'hA, 0);
    do_body(32'hB, 0);
    do_body(32'hC, 1);
    drain();
    // header-only packet
    do_req(4'd1, 4'd1, 8'd0, mk_hdr(4'd1, 4'd1, 8'd0));
    @(posedge noc_clk); #1;
    chk("len0_flags", {snd_valid, is_header, is_tail}, 3'b111);
    chk("len0_req_ready", req_ready, 1);
    drain();
    // VC gating of the header only
    vc_ready = 0;
    do_req(4'd4, 4'd5, 8'd2, mk_hdr(4'd4, 4'd5, 8'd2));
    repeat (5) begin
      @(posedge noc_clk); #1;
      chk("novc_valid", snd_valid, 0);
    end
    vc_ready = 1;
    @(posedge noc_clk); #1;
    chk("vc_hdr", {snd_valid, is_header}, 2'b11);
    vc_ready = 0;
    do_body(32'h1111_0001, 0);
    do_body(32'h1111_0002, 1);
    drain();
    vc_ready = 1;
    // random backpressure
    rnd_ready = 1;
    repeat (100) send_pkt(4'($urandom), 4'($urandom), 8'($urandom_range(0, 5)));
    drain();
    rnd_ready = 0;
    // async reset mid-packet
    do_req(4'd6, 4'd6, 8'd4, mk_hdr(4'd6, 4'd6, 8'd4));
    do_body(32'hD1, 0);
    pl_valid = 1; pl_data = 32'hD2;
    @(posedge noc_clk); #3;
    rst_n = 0;
    #1;
    chk("rst_mid_valid", snd_valid, 0);
    chk("rst_mid_busy", busy, 0);
    pl_valid = 0;
    sb.delete();
    pkt_cnt = 0;
    repeat (2) @(posedge noc_clk);
    #1 rst_n = 1;
    @(posedge noc_clk); #1;
    send_pkt(4'd7, 4'd8, 8'd2);
    drain();
    // sequence-number wrap (seq stays 0 when the counter is not built)
    rnd_ready = 1;
    repeat (257) send_pkt(4'($urandom), 4'($urandom), 8'd0);
    drain();
    rnd_ready = 0;
    chk("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
